// File: rtl/apb_mc_pkg.sv
// Shared types and sizing helpers for the multi-channel APB slave front-end.
package apb_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STROBE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Index width never collapses to zero so a single-channel build still has a field to check.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned CH_IDX_W   = idx_w(DEF_NUM_CH);
  localparam int unsigned STRB_W     = DEF_DATA_W / 8;
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/apb_mc_decode.sv
// Combinational address decode: channel index and out-of-range error.
module apb_mc_decode
  import apb_mc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_ADDR_W = 8,
  parameter int unsigned IDX_W     = idx_w(NUM_CH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  ch_sel_c,
  output logic              dec_err_c
);

  logic [ADDR_W-1:0] upper;

  always_comb begin
    ch_sel_c  = addr[CH_ADDR_W +: IDX_W];
    upper     = addr >> (CH_ADDR_W + IDX_W);
    dec_err_c = (32'(ch_sel_c) >= NUM_CH) || (upper != '0);
  end

endmodule

// File: rtl/apb_slave_mc.sv
// Multi-channel APB4 slave front-end with configurable wait states.
// Optional build macro APB_STRB_EN: forward write byte strobes to ch_wstrb.
module apb_slave_mc
  import apb_mc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_ADDR_W   = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     tim_psel,
  input  logic                     tim_penable,
  input  logic                     tim_pwrite,
  input  logic [ADDR_W-1:0]        tim_paddr,
  input  logic [DATA_W-1:0]        tim_pwdata,
  input  logic [DATA_W/8-1:0]      tim_pstrb,
  output logic [DATA_W-1:0]        tim_prdata,
  output logic                     tim_pready,
  output logic                     tim_pslverr,
  output logic [NUM_CH-1:0]        ch_wr_en,
  output logic [NUM_CH-1:0]        ch_rd_en,
  output logic [CH_ADDR_W-1:0]     ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  output logic [DATA_W/8-1:0]      ch_wstrb,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_error
);

  localparam int unsigned IDX_W = idx_w(NUM_CH);
  localparam int unsigned BE_W  = DATA_W / 8;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [BE_W-1:0]     wstrb_d, strb_in;
  logic [NUM_CH-1:0]   wr_en_d, rd_en_d, sel_oh;
  logic [DATA_W-1:0]   prdata_d, rdata_sel;
  logic                pready_d, pslverr_d, err_sel;
  logic [IDX_W-1:0]    ch_sel;
  logic                dec_err;

  apb_mc_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_CH    (NUM_CH),
    .CH_ADDR_W (CH_ADDR_W),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr      (addr_q),
    .ch_sel_c  (ch_sel),
    .dec_err_c (dec_err)
  );

`ifdef APB_STRB_EN
  assign strb_in = tim_pstrb;
`else
  logic unused_pstrb;
  assign unused_pstrb = ^tim_pstrb;
  assign strb_in      = '1;
`endif

  assign ch_addr = addr_q[CH_ADDR_W-1:0];

  // Channel mux: one-hot select plus the selected channel's read data and error.
  always_comb begin
    sel_oh    = '0;
    rdata_sel = '0;
    err_sel   = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (ch_sel == IDX_W'(k)) begin
        sel_oh[k] = 1'b1;
        rdata_sel = ch_rdata[k*DATA_W +: DATA_W];
        err_sel   = ch_error[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = ch_wdata;
    wstrb_d   = ch_wstrb;
    wr_en_d   = '0;
    rd_en_d   = '0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    pready_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tim_psel && !tim_penable) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_STATES);
          addr_d  = tim_paddr;
          wr_d    = tim_pwrite;
          wdata_d = tim_pwdata;
          wstrb_d = tim_pwrite ? strb_in : '1;
        end
      end
      ST_WAIT: begin
        if (!tim_psel || !tim_penable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_STROBE;
          if (!dec_err) begin
            if (wr_q) wr_en_d = sel_oh;
            else      rd_en_d = sel_oh;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        state_d   = ST_RESP;
        pready_d  = 1'b1;
        pslverr_d = dec_err | err_sel;
        prdata_d  = (!wr_q && !dec_err) ? rdata_sel : '0;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      ch_wdata    <= '0;
      ch_wstrb    <= '0;
      ch_wr_en    <= '0;
      ch_rd_en    <= '0;
      tim_prdata  <= '0;
      tim_pready  <= 1'b0;
      tim_pslverr <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      ch_wdata    <= wdata_d;
      ch_wstrb    <= wstrb_d;
      ch_wr_en    <= wr_en_d;
      ch_rd_en    <= rd_en_d;
      tim_prdata  <= prdata_d;
      tim_pready  <= pready_d;
      tim_pslverr <= pslverr_d;
    end
  end

endmodule

// File: doc/apb_slave_mc.md
Name: apb_slave_mc

Overview:
Parametrised multi-channel APB4 slave front-end, successor to the single-channel timer APB slave. Decodes the APB address into NUM_CH register-bank channels and inserts a configurable number of wait states. Issues one-cycle per-channel read/write strobes and returns registered read data, pready and pslverr. Sits between the system APB interconnect and the per-channel timer register banks.

Parameters:
ADDR_W, 12, APB address width (bits)
DATA_W, 32, APB data width; multiple of 8
NUM_CH, 4, number of channels, 1..16
CH_ADDR_W, 8, byte-address bits inside one channel window
WAIT_STATES, 1, extra wait cycles before the strobe, 0..15

Ports:
sys_clk  in  1  clock, rising edge
sys_rst  in  1  synchronous active-high reset
tim_psel  in  1  APB select
tim_penable  in  1  APB enable
tim_pwrite  in  1  1=write, 0=read
tim_paddr  in  ADDR_W  byte address
tim_pwdata  in  DATA_W  write data
tim_pstrb  in  DATA_W/8  byte strobes
tim_prdata  out  DATA_W  read data, valid with tim_pready
tim_pready  out  1  transfer complete
tim_pslverr  out  1  error, valid with tim_pready
ch_wr_en  out  NUM_CH  one-hot write strobe
ch_rd_en  out  NUM_CH  one-hot read strobe
ch_addr  out  CH_ADDR_W  latched in-channel offset
ch_wdata  out  DATA_W  latched write data
ch_wstrb  out  DATA_W/8  latched byte strobes
ch_rdata  in  NUM_CH*DATA_W  per-channel read data, channel k at [k*DATA_W +: DATA_W], combinational in the rd_en cycle
ch_error  in  NUM_CH  per-channel error, valid in the strobe cycle

Behaviour:
- Reset (sys_rst=1 at an edge): state IDLE; all outputs 0. Reset mid-transfer aborts with no strobe and no pready.
- Channel index = paddr[CH_ADDR_W +: clog2(NUM_CH)]. Decode error if index >= NUM_CH or any paddr bit above the index field is 1.
- FSM states IDLE, WAIT, STROBE, RESP:
  - IDLE: when psel=1 and penable=0 are sampled, latch paddr, pwrite, pwdata and pstrb; load cnt=WAIT_STATES; go to WAIT.
  - WAIT: if psel=0 or penable=0, go to IDLE (abort, nothing issued). Else if cnt==0, go to STROBE; otherwise decrement cnt.
  - STROBE: assert exactly one bit of ch_wr_en or ch_rd_en for exactly one cycle. No strobe is issued on a decode error. At the closing edge, register tim_prdata (ch_rdata of the selected channel for a valid read, 0 otherwise) and tim_pslverr (ch_error[sel] | decode_err). Go to RESP unconditionally.
  - RESP: tim_pready=1 for exactly one cycle, then go to IDLE. tim_prdata and tim_pslverr are forced to 0 outside RESP.
- Latency: the master sees WAIT_STATES+2 access cycles with pready=0, then 1 cycle with pready=1.
- ch_addr, ch_wdata and ch_wstrb hold their last latched value between transfers.
- A setup phase presented in the cycle after RESP is accepted, so back-to-back transfers work.
- Inputs that change during WAIT are ignored; the values latched at setup are used.
- Writes always return tim_prdata=0.

Optional Feature:
APB_STRB_EN
- Defined: ch_wstrb = latched tim_pstrb. A write with pstrb=0 is still strobed.
- Undefined: tim_pstrb is ignored and ch_wstrb is all ones. Reads always drive ch_wstrb all ones in both builds.

Decomposition:
- Package apb_mc_pkg holds:
  - the state enum (IDLE/WAIT/STROBE/RESP), 2-bit encoding;
  - localparams CH_IDX_W = clog2(NUM_CH), STRB_W = DATA_W/8, CNT_W = 4.
- One sub-module, apb_mc_decode: combinational address-to-channel index and decode_err, instantiated once.

Test Plan:
- Write, WAIT_STATES=1, paddr=0x104, pwdata=0xDEADBEEF: ch_wr_en=0b0010 for 1 cycle, ch_addr=0x04, ch_wdata=0xDEADBEEF; pready=1 in the 4th access cycle; pslverr=0.
- Read of channel 3 (paddr=0x300), ch_rdata[3]=0x12345678: ch_rd_en=0b1000 for 1 cycle; prdata=0x12345678 with pready; prdata=0 in the next cycle.
- Write to channel 2 with ch_error[2]=1 in the strobe cycle: pslverr=1 with pready=1. Read to paddr=0x400 (decode error): no strobe, pslverr=1, prdata=0.
- Abort by psel=0 in WAIT (WAIT_STATES=3): no strobe, pready stays 0, FSM in IDLE; an immediately following read completes normally.
- sys_rst=1 during WAIT: all outputs 0 next cycle, no strobe. Back-to-back write then read with WAIT_STATES=0: each takes 3 cycles after setup and each strobe occurs exactly once.
- APB_STRB_EN defined, pstrb=0b0101: ch_wstrb=0b0101. Undefined, same stimulus: ch_wstrb=0b1111.
